// File: rtl/demux1to2_64.sv
// rtl/demux1to2_64.sv - 1:2 demux into two DEPTH x 64 FIFOs; DEMUX_CNT_EN adds per-port delivered-word counters
module demux1to2_64 #(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [63:0]               in_data,
   input  logic                      in_valid,
   input  logic                      sel,
   output logic                      in_ready,
   output logic [63:0]               o0_data,
   output logic                      o0_valid,
   input  logic                      o0_ready,
   output logic [63:0]               o1_data,
   output logic                      o1_valid,
   input  logic                      o1_ready,
   output logic [$clog2(DEPTH):0]    lvl0,
   output logic [$clog2(DEPTH):0]    lvl1,
   output logic [15:0]               cnt0,
   output logic [15:0]               cnt1
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [63:0]   mem0_q [DEPTH];
   logic [63:0]   mem1_q [DEPTH];
   logic [AW-1:0] wp0_q, wp0_d, rp0_q, rp0_d;
   logic [AW-1:0] wp1_q, wp1_d, rp1_q, rp1_d;
   logic [LW-1:0] lvl0_q, lvl0_d, lvl1_q, lvl1_d;
   logic          push0, push1, pop0, pop1;

   // Handshakes: in_ready looks only at the selected FIFO's level, so a
   // same-cycle pop on a full FIFO never opens room for a push.
   always_comb begin
      in_ready = sel ? (lvl0_q != FULL_LVL) : (lvl1_q != FULL_LVL);
      o0_valid = (lvl0_q != '0);
      o1_valid = (lvl1_q != '0);
      push0    = in_valid && in_ready && sel;
      push1    = in_valid && in_ready && !sel;
      pop0     = o0_valid && o0_ready;
      pop1     = o1_valid && o1_ready;
   end

   // Head words are forced to zero while a FIFO is empty, so stale memory never leaks out.
   always_comb begin
      o0_data = o0_valid ? mem0_q[rp0_q] : 64'h0;
      o1_data = o1_valid ? mem1_q[rp1_q] : 64'h0;
      lvl0    = lvl0_q;
      lvl1    = lvl1_q;
   end

   // Next-state pointers and levels; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wp0_d  = wp0_q + AW'(push0);
      rp0_d  = rp0_q + AW'(pop0);
      wp1_d  = wp1_q + AW'(push1);
      rp1_d  = rp1_q + AW'(pop1);
      lvl0_d = lvl0_q + LW'(push0) - LW'(pop0);
      lvl1_d = lvl1_q + LW'(push1) - LW'(pop1);
   end

   // Pointer and level registers, cleared asynchronously so buffered words are discarded at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp0_q  <= '0;
         rp0_q  <= '0;
         wp1_q  <= '0;
         rp1_q  <= '0;
         lvl0_q <= '0;
         lvl1_q <= '0;
      end else begin
         wp0_q  <= wp0_d;
         rp0_q  <= rp0_d;
         wp1_q  <= wp1_d;
         rp1_q  <= rp1_d;
         lvl0_q <= lvl0_d;
         lvl1_q <= lvl1_d;
      end
   end

   // Storage arrays need no reset: their contents are only visible when the level is non-zero.
   always_ff @(posedge clk) begin
      if (push0) mem0_q[wp0_q] <= in_data;
      if (push1) mem1_q[wp1_q] <= in_data;
   end

`ifdef DEMUX_CNT_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // Delivered-word counters advance on every pop and wrap at 16 bits.
   always_comb begin
      cnt0_d = cnt0_q + 16'(pop0);
      cnt1_d = cnt1_q + 16'(pop1);
   end

   // Counter registers share the asynchronous reset of the FIFO state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`else
   assign cnt0 = 16'h0;
   assign cnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_demux1to2_64.sv
// tb/tb_demux1to2_64.sv - randomized queue-model bench for demux1to2_64 at DEPTH 2 and 4 (honours DEMUX_CNT_EN)
module tb_demux1to2_64;

   localparam bit CNT_ON =
`ifdef DEMUX_CNT_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        sel = 1'b0;
   logic        o0_ready = 1'b0;
   logic        o1_ready = 1'b0;

   logic        a_in_ready, a_o0_valid, a_o1_valid;
   logic [63:0] a_o0_data, a_o1_data;
   logic [1:0]  a_lvl0, a_lvl1;
   logic [15:0] a_cnt0, a_cnt1;

   logic        b_in_ready, b_o0_valid, b_o1_valid;
   logic [63:0] b_o0_data, b_o1_data;
   logic [2:0]  b_lvl0, b_lvl1;
   logic [15:0] b_cnt0, b_cnt1;

   int n_vec = 0;
   int n_err = 0;

   // reference model: one queue per (instance, port); index = inst*2 + port
   logic [63:0] mq [4][$];
   logic [15:0] mc [4];
   int          depth_of [2] = '{2, 4};

   demux1to2_64 #(.DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sel(sel),
      .in_ready(a_in_ready),
      .o0_data(a_o0_data), .o0_valid(a_o0_valid), .o0_ready(o0_ready),
      .o1_data(a_o1_data), .o1_valid(a_o1_valid), .o1_ready(o1_ready),
      .lvl0(a_lvl0), .lvl1(a_lvl1), .cnt0(a_cnt0), .cnt1(a_cnt1)
   );

   demux1to2_64 #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sel(sel),
      .in_ready(b_in_ready),
      .o0_data(b_o0_data), .o0_valid(b_o0_valid), .o0_ready(o0_ready),
      .o1_data(b_o1_data), .o1_valid(b_o1_valid), .o1_ready(o1_ready),
      .lvl0(b_lvl0), .lvl1(b_lvl1), .cnt0(b_cnt0), .cnt1(b_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] head(input int m);
      return (mq[m].size() != 0) ? mq[m][0] : 64'h0;
   endfunction

   // model update: decide readiness/pops from pre-edge occupancy, then apply
   always @(posedge clk or posedge rst) begin
      int  d;
      bit  rdy, p0, p1;
      if (rst) begin
         for (int m = 0; m < 4; m++) begin
            mq[m].delete();
            mc[m] = 16'h0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            d   = depth_of[i];
            rdy = sel ? (mq[i*2].size() != d) : (mq[i*2+1].size() != d);
            p0  = (mq[i*2].size() != 0) && o0_ready;
            p1  = (mq[i*2+1].size() != 0) && o1_ready;
            if (p0) begin void'(mq[i*2].pop_front());   mc[i*2]++;   end
            if (p1) begin void'(mq[i*2+1].pop_front()); mc[i*2+1]++; end
            if (in_valid && rdy) mq[i*2 + (sel ? 0 : 1)].push_back(in_data);
         end
      end
   end

   task automatic chk_inst(input string tag, input int i, input logic rdy,
                           input logic v0, input logic [63:0] d0, input logic [63:0] l0, input logic [15:0] c0,
                           input logic v1, input logic [63:0] d1, input logic [63:0] l1, input logic [15:0] c1);
      int d;
      logic [63:0] er;
      d  = depth_of[i];
      er = sel ? 64'(mq[i*2].size() != d) : 64'(mq[i*2+1].size() != d);
      chk({tag, ".in_ready"}, 64'(rdy), er);
      chk({tag, ".o0_valid"}, 64'(v0), 64'(mq[i*2].size() != 0));
      chk({tag, ".o0_data"},  d0, head(i*2));
      chk({tag, ".lvl0"},     l0, 64'(mq[i*2].size()));
      chk({tag, ".cnt0"},     64'(c0), CNT_ON ? 64'(mc[i*2]) : 64'h0);
      chk({tag, ".o1_valid"}, 64'(v1), 64'(mq[i*2+1].size() != 0));
      chk({tag, ".o1_data"},  d1, head(i*2+1));
      chk({tag, ".lvl1"},     l1, 64'(mq[i*2+1].size()));
      chk({tag, ".cnt1"},     64'(c1), CNT_ON ? 64'(mc[i*2+1]) : 64'h0);
   endtask

   // every-cycle compare of both instances against the model
   always @(negedge clk) begin
      chk_inst("A", 0, a_in_ready, a_o0_valid, a_o0_data, 64'(a_lvl0), a_cnt0,
               a_o1_valid, a_o1_data, 64'(a_lvl1), a_cnt1);
      chk_inst("B", 1, b_in_ready, b_o0_valid, b_o0_data, 64'(b_lvl0), b_cnt0,
               b_o1_valid, b_o1_data, 64'(b_lvl1), b_cnt1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      o0_ready = 1'b0;
      o1_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] got [$];
      int k;

      // reset state
      do_reset();
      chk("rst.in_ready", 64'(a_in_ready), 64'h1);
      chk("rst.o0_valid", 64'(a_o0_valid), 64'h0);
      chk("rst.o0_data",  a_o0_data, 64'h0);
      chk("rst.lvl1",     64'(a_lvl1), 64'h0);
      chk("rst.cnt1",     64'(a_cnt1), 64'h0);

      // routing: sel=1 -> port 0, sel=0 -> port 1
      in_valid = 1'b1; sel = 1'b1; in_data = 64'hA5A5_0000_0000_0001;
      tick();
      sel = 1'b0; in_data = 64'h5A5A_0000_0000_0002;
      tick();
      in_valid = 1'b0;
      chk("route.o0_data", a_o0_data, 64'hA5A5_0000_0000_0001);
      chk("route.o1_data", a_o1_data, 64'h5A5A_0000_0000_0002);
      chk("route.lvl0",    64'(a_lvl0), 64'h1);
      chk("route.lvl1",    64'(a_lvl1), 64'h1);

      // asynchronous reset mid-cycle with both FIFOs occupied
      #2 rst = 1'b1;
      #1;
      chk("arst.o0_valid", 64'(a_o0_valid), 64'h0);
      chk("arst.o1_valid", 64'(b_o1_valid), 64'h0);
      chk("arst.lvl0",     64'(a_lvl0), 64'h0);
      chk("arst.o1_data",  a_o1_data, 64'h0);
      chk("arst.in_ready", 64'(a_in_ready), 64'h1);
      tick();
      rst = 1'b0;
      chk("arst.in_ready_after", 64'(a_in_ready), 64'h1);
      in_valid = 1'b1; sel = 1'b1; in_data = 64'hDEAD_BEEF_0000_0007;
      tick();
      in_valid = 1'b0;
      chk("arst.first_head", a_o0_data, 64'hDEAD_BEEF_0000_0007);

      // full / backpressure on the DEPTH=2 instance
      do_reset();
      in_valid = 1'b1; sel = 1'b1;
      in_data = 64'h11; tick();
      in_data = 64'h22; tick();
      in_data = 64'h33;
      chk("full.in_ready", 64'(a_in_ready), 64'h0);
      chk("full.lvl0",     64'(a_lvl0), 64'h2);
      tick();
      o0_ready = 1'b1;
      chk("full.in_ready_pop", 64'(a_in_ready), 64'h0);
      tick();
      o0_ready = 1'b0; in_valid = 1'b0;
      chk("full.lvl0_after", 64'(a_lvl0), 64'h1);
      chk("full.head_after", a_o0_data, 64'h22);

      // streaming 0..99 through port 1
      do_reset();
      o1_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_data = 64'(i);
         tick();
         chk("stream.data", a_o1_data, 64'(i));
         chk("stream.lvl1", 64'(a_lvl1), 64'h1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream.drained", 64'(a_lvl1), 64'h0);
      o1_ready = 1'b0;

      // wrap-around on the DEPTH=4 instance: 10 words, irregular pops
      do_reset();
      k = 0;
      sel = 1'b1;
      for (int c = 0; c < 200 && got.size() < 10; c++) begin
         in_valid = (k < 10);
         in_data  = 64'(100 + k);
         o0_ready = (c % 3 != 0) || (k >= 10);
         @(negedge clk);
         if (b_o0_valid && o0_ready) got.push_back(b_o0_data);
         if (in_valid && b_in_ready) k++;
         tick();
      end
      in_valid = 1'b0; o0_ready = 1'b0;
      chk("wrap.count", 64'(got.size()), 64'd10);
      for (int i = 0; i < got.size(); i++) chk("wrap.order", got[i], 64'(100 + i));

      // counter: 65536 pops on port 1
      do_reset();
      sel = 1'b0; o1_ready = 1'b1; in_valid = 1'b1;
      for (int j = 0; j < 65536; j++) begin
         in_data = 64'(j);
         tick();
         if (j == 1000) chk("cnt.mid", 64'(a_cnt1), CNT_ON ? 64'd1000 : 64'h0);
      end
      in_valid = 1'b0;
      tick();
      chk("cnt.wrap_a", 64'(a_cnt1), 64'h0);
      chk("cnt.wrap_b", 64'(b_cnt1), 64'h0);
      o1_ready = 1'b0;

      // randomized traffic with occasional mid-cycle resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom % 4) != 0;
         sel      = $urandom % 2;
         in_data  = {$urandom, $urandom};
         o0_ready = ($urandom % 3) != 0;
         o1_ready = ($urandom % 3) != 0;
         if ($urandom % 200 == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
